// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the P8 UART receive and transmit paths.
// Both directions use 16x oversampling of an 8N1 frame.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_MID_TICK   = 8;

  localparam int UART_TICK_W = $clog2(UART_OVERSAMPLE);
  localparam int UART_BIT_W  = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // True on the tick that completes the n-th oversample period of the current count.
  function automatic logic tick_is(input logic tick, input logic [UART_TICK_W-1:0] cnt,
                                   input int n);
    return tick && (cnt == UART_TICK_W'(n - 1));
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one-cycle tick every TICK_DIV cycles, restartable
// so the sampling phase can be aligned to a detected start edge.
module uart_tick_gen #(
  parameter int TICK_DIV = 27
) (
  input  logic clk_in,
  input  logic sys_rstn,
  input  logic restart,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit start re-check, a one-entry
// holding register and sticky framing-error / overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICK_DIV = 27
) (
  input  logic       clk_in,
  input  logic       sys_rstn,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  uart_state_e state, next_state;

  logic rxd_meta, rxd_sync, rxd_prev;
  logic fall, restart, tick;
  logic mid_tick, last_tick;
  logic sample_data, stop_good, stop_bad;

  logic [UART_TICK_W-1:0]    tick_cnt;
  logic [UART_BIT_W-1:0]     bit_cnt;
  logic [UART_DATA_BITS-1:0] shift_reg;

  // The raw line is asynchronous; only rxd_sync may feed decisions.
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign fall    = rxd_prev && !rxd_sync;
  assign restart = (state == ST_IDLE) && fall;

  uart_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_in   (clk_in),
    .sys_rstn (sys_rstn),
    .restart  (restart),
    .tick     (tick)
  );

  assign mid_tick  = tick_is(tick, tick_cnt, UART_MID_TICK);
  assign last_tick = tick_is(tick, tick_cnt, UART_OVERSAMPLE);

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal written here gets a default first so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state  = state;
    sample_data = 1'b0;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fall) next_state = ST_START;
      end
      ST_START: begin
        // A line back high at mid start bit was a glitch, not a frame.
        if (mid_tick) next_state = rxd_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (last_tick) begin
          sample_data = 1'b1;
          if (bit_cnt == UART_BIT_W'(UART_DATA_BITS - 1)) next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (last_tick) begin
          if (rxd_sync) begin
            stop_good  = 1'b1;
            next_state = ST_IDLE;
          end else begin
            stop_bad   = 1'b1;
            next_state = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_sync) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Tick count restarts at every state change so DATA/STOP count from mid-bit.
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      tick_cnt <= '0;
    end else if (state == ST_IDLE || state != next_state) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (state != ST_DATA) begin
        bit_cnt <= '0;
      end else if (sample_data) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (sample_data) shift_reg <= {rxd_sync, shift_reg[UART_DATA_BITS-1:1]};
    end
  end

  // A simultaneous ack frees the holding register in time for the new byte.
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (stop_good && (!rx_valid || rx_ack)) begin
      rx_data  <= shift_reg;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

  // New error events take priority over err_clr.
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_bad)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (stop_good && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (err_clr)                     overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state != ST_IDLE);
    end
  end

endmodule
